div_seq: RTL and testbench
==========================

# div_seq

Iterative signed/unsigned divider for DIV/IDIV, byte and word forms. It sits beside the execution ALU and feeds its multiply/divide result path with a 32-bit `{remainder, quotient}` word, in the same format as the multiplier result. Each operation takes several cycles and uses a start/busy/done handshake. Divide-by-zero and quotient overflow are raised as a divide-error flag; the control unit turns that flag into INT 0.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a divide; sampled only in IDLE
- x  in  32  dividend; word: x[31:0] (DX:AX); byte: x[15:0] (AX)
- y  in  16  divisor; word: y[15:0]; byte: y[7:0]
- word_op  in  1  1 = 16-bit divide, 0 = 8-bit divide
- signed_op  in  1  1 = IDIV, 0 = DIV
- out  out  32  word: {rem16, quo16}; byte: {16'd0, rem8, quo8}; reset 0
- busy  out  1  high from the cycle after start is accepted until done; reset 0
- done  out  1  one-cycle pulse when the result or exception is valid; reset 0
- exc  out  1  divide error, valid with done and held until the next accepted start; reset 0

## Operation
- Operand width: N = 16 when word_op = 1, N = 8 otherwise.
- The operands, word_op and signed_op are latched at start; later input changes are ignored.
- States: IDLE, DIV, FIX.
  - IDLE: on start, latch the operands and compute magnitudes.
    - |x|: two's-complement of the 2N-bit dividend if signed_op and its MSB is set.
    - |y|: likewise for the N-bit divisor.
    - Record qneg = sx ^ sy and rneg = sx.
  - IDLE early errors, checked at start: |y| == 0, or the upper N bits of |x| >= |y|. Either sets an error and goes to FIX. Otherwise go to DIV with counter = N.
  - DIV: one restoring step per cycle on an (N+1)-bit partial remainder.
    - Shift in the next dividend bit.
    - Subtract |y| when the result is non-negative, and shift the quotient bit in.
    - Decrement the counter; go to FIX after N steps.
  - FIX: apply signs. quo = qneg ? -q : q; rem = rneg ? -r : r.
    - Signed overflow: q > 2^(N-1)-1 is an error (8086 range ±0x7FFF / ±0x7F; a quotient of -0x8000 or -0x80 also faults).
    - No error: load `out` with the formatted result and set exc = 0.
    - Error: leave `out` unchanged and set exc = 1.
    - In both cases pulse done and return to IDLE.
- start while busy: ignored; there is no queueing.
- Remainder takes the sign of the dividend; the quotient truncates toward zero.
- Byte mode: out[31:16] = 0.
- Reset at any point, including mid-DIV: state IDLE, all outputs 0, the operation is abandoned.

## Timing
- Cycle 0 is the cycle in which start is high in IDLE.
- Normal case:
  - DIV occupies cycles 1..N and FIX is cycle N+1.
  - done = 1 in cycle N+2: cycle 18 for word, cycle 10 for byte.
  - busy = 1 in cycles 1..N+1.
- Early error: FIX in cycle 1, done = 1 and exc = 1 in cycle 2.
- `out` and `exc` become valid in the same cycle as done and are stable until the next accepted start.
- The unit is back in IDLE in the done cycle, so a new start may be asserted in that same cycle.
- Throughput: one divide per N+2 cycles.

## Test plan
- Unsigned word: x = 0x000186A0, y = 0x0007 -> cycle 18: done = 1, out = 0x000537CD (q = 14285, r = 5), exc = 0.
- Unsigned byte: x = 0x0064, y = 0x0007 -> cycle 10: done = 1, out = 0x0000020E.
- Signed byte: x = 0xFF9C (-100), y = 0x0007 -> cycle 10: out = 0x0000FEF2 (q = -14, r = -2).
- Signed word: x = 0xFFFE7960 (-100000), y = 0xFFF9 (-7) -> out = 0xFFFB37CD (q = 14285, r = -5).
- Errors, with `out` holding its prior value in every case:
  - Divide by zero, y = 0 -> cycle 2: done = 1, exc = 1.
  - Unsigned word, x = 0x00070000, y = 7 -> cycle 2: exc = 1.
  - Signed byte, x = 0x0080, y = 0x01 -> cycle 10: exc = 1 (quotient 128 > 127).
- Handshake and reset:
  - A start pulse during busy is ignored, and the result is unaffected.
  - Asserting rst low in cycle 5 of a word divide -> busy, done, exc and out all read 0 immediately.
  - A new start after reset completes correctly.

Source files
------------

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/IDIV, byte and word forms.
// Produces {rem, quo} in the multiplier result format and flags divide errors.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [15:0] y,
  input  logic        word_op,
  input  logic        signed_op,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        exc
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t      state, state_nx;
  logic        wd, sgn, qneg, rneg, err;
  logic [4:0]  cnt;
  logic [16:0] rem;
  logic [15:0] quo;
  logic [15:0] ay_r;

  // Operand magnitudes, computed combinationally from the live inputs at start.
  logic        sx, sy, early_err;
  logic [31:0] xw, xneg, ax;
  logic [15:0] yw, yneg, ay, xhi, xlo;

  always_comb begin
    sx   = signed_op & (word_op ? x[31] : x[15]);
    sy   = signed_op & (word_op ? y[15] : y[7]);
    xw   = word_op ? x : {16'd0, x[15:0]};
    xneg = -xw;
    ax   = !sx ? xw : (word_op ? xneg : {16'd0, xneg[15:0]});
    yw   = word_op ? y : {8'd0, y[7:0]};
    yneg = -yw;
    ay   = !sy ? yw : (word_op ? yneg : {8'd0, yneg[7:0]});
    xhi  = word_op ? ax[31:16] : {8'd0, ax[15:8]};
    xlo  = word_op ? ax[15:0]  : {8'd0, ax[7:0]};
    // A high half >= divisor means the quotient cannot fit in N bits.
    early_err = (ay == 16'd0) || (xhi >= ay);
  end

  // Restoring step: next dividend bit comes out of the top of the quotient shifter.
  logic        nb, ge;
  logic [16:0] t, diff;

  always_comb begin
    nb   = wd ? quo[15] : quo[7];
    t    = {rem[15:0], nb};
    diff = t - {1'b0, ay_r};
    ge   = (t >= {1'b0, ay_r});
  end

  // Sign fix-up and overflow check.
  logic [15:0] q, r, qs, rs;
  logic        ovf, fault;
  logic [31:0] res;

  always_comb begin
    q     = wd ? quo : {8'd0, quo[7:0]};
    r     = wd ? rem[15:0] : {8'd0, rem[7:0]};
    qs    = qneg ? -q : q;
    rs    = rneg ? -r : r;
    ovf   = sgn & (wd ? (q > 16'h7FFF) : (q > 16'h007F));
    fault = err | ovf;
    res   = wd ? {rs, qs} : {16'd0, rs[7:0], qs[7:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = early_err ? FIX : DIV;
      DIV:     if (cnt == 5'd1) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      exc  <= 1'b0;
      wd   <= 1'b0;
      sgn  <= 1'b0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      err  <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      ay_r <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          wd   <= word_op;
          sgn  <= signed_op;
          qneg <= sx ^ sy;
          rneg <= sx;
          err  <= early_err;
          ay_r <= ay;
          rem  <= {1'b0, xhi};
          quo  <= xlo;
          cnt  <= word_op ? 5'd16 : 5'd8;
          busy <= 1'b1;
          exc  <= 1'b0;
        end
        DIV: begin
          rem <= ge ? diff : t;
          quo <= {quo[14:0], ge};
          cnt <= cnt - 5'd1;
        end
        FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          exc  <= fault;
          if (!fault) out <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, results, divide errors, handshake and reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [15:0] y = '0;
  logic        word_op = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] out;
  logic        busy, done, exc;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_out = '0;

  div_seq dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .word_op(word_op), .signed_op(signed_op),
    .out(out), .busy(busy), .done(done), .exc(exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one divide; cycle 0 is the cycle start is high. Inputs are scrambled
  // after cycle 0 to show they were latched.
  task automatic do_div(input string tag, input logic [31:0] xv, input logic [15:0] yv,
                        input logic w, input logic s, input int exp_cyc,
                        input logic [31:0] exp_out, input logic exp_exc);
    int  cyc;
    logic got;
    @(negedge clk);
    x = xv; y = yv; word_op = w; signed_op = s; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        x = $urandom; y = 16'($urandom); word_op = ~w; signed_op = ~s;
        chk({tag, " busy@1"}, {31'd0, busy}, 32'd1);
      end
      if (done) got = 1'b1;
    end
    chk({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " out"}, out, exp_out);
    chk({tag, " exc"}, {31'd0, exc}, {31'd0, exp_exc});
    @(negedge clk);
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " exc held"}, {31'd0, exc}, {31'd0, exp_exc});
    if (!exp_exc) last_out = exp_out;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst out", out, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst exc", {31'd0, exc}, 32'd0);
    rst = 1'b1;

    do_div("uword", 32'h000186A0, 16'h0007, 1'b1, 1'b0, 18, 32'h000537CD, 1'b0);
    do_div("ubyte", 32'h00000064, 16'h0007, 1'b0, 1'b0, 10, 32'h0000020E, 1'b0);
    do_div("sbyte", 32'h0000FF9C, 16'h0007, 1'b0, 1'b1, 10, 32'h0000FEF2, 1'b0);
    do_div("sword", 32'hFFFE7960, 16'hFFF9, 1'b1, 1'b1, 18, 32'hFFFB37CD, 1'b0);
    do_div("div0", 32'h00001234, 16'h0000, 1'b1, 1'b0, 2, last_out, 1'b1);
    do_div("uword ovf", 32'h00070000, 16'h0007, 1'b1, 1'b0, 2, last_out, 1'b1);
    do_div("sbyte ovf", 32'h00000080, 16'h0001, 1'b0, 1'b1, 10, last_out, 1'b1);
    // Signed word -32768 / 1 faults even though it is representable as -0x8000
    do_div("sword -8000", 32'hFFFF8000, 16'h0001, 1'b1, 1'b1, 18, last_out, 1'b1);
    // Exact boundary that fits: -128 / 1 in byte mode... quotient magnitude 128 faults,
    // while 127 / 1 is fine.
    do_div("sbyte 7f", 32'h0000007F, 16'h0001, 1'b0, 1'b1, 10, 32'h0000007F, 1'b0);
    do_div("sbyte -x/-y", 32'h0000FF9C, 16'h00F9, 1'b0, 1'b1, 10, 32'h0000FE0E, 1'b0);

    // Start pulse while busy must be ignored.
    begin
      int cyc;
      @(negedge clk);
      x = 32'h000186A0; y = 16'h0007; word_op = 1'b1; signed_op = 1'b0; start = 1'b1;
      cyc = 0;
      while (!done && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin start = 1'b0; x = 32'h00000064; y = 16'h0003; word_op = 1'b0; end
        if (cyc == 3) start = 1'b1;
        if (cyc == 4) start = 1'b0;
      end
      chk("busy-start done cycle", 32'(cyc), 32'd18);
      chk("busy-start out", out, 32'h000537CD);
      @(negedge clk);
      chk("busy-start idle", {31'd0, busy}, 32'd0);
    end

    // Reset mid-divide.
    @(negedge clk);
    x = 32'h000186A0; y = 16'h0007; word_op = 1'b1; signed_op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out", out, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst exc", {31'd0, exc}, 32'd0);
    @(negedge clk); rst = 1'b1;
    last_out = '0;
    do_div("after rst", 32'h00000064, 16'h0007, 1'b0, 1'b0, 10, 32'h0000020E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
